// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared types and constants for the VPU command responder
//
// Purpose: FSM state encoding, the write-back error code used when the
// engine watchdog fires, and the field layout of the RO command word.
// Ports: none (package).
package vpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } vpu_state_e;

  // Return object reported to the CPU when the engine is aborted.
  localparam logic [15:0] VPU_ERR_RO = 16'hFFFF;

  // RO command word layout: [15:12] engine op, [11:0] argument.
  localparam int RO_OP_MSB  = 15;
  localparam int RO_OP_LSB  = 12;
  localparam int RO_ARG_MSB = 11;
  localparam int RO_ARG_LSB = 0;

  function automatic logic [3:0] ro_op(input logic [15:0] ro);
    return ro[RO_OP_MSB:RO_OP_LSB];
  endfunction

endpackage

// File: rtl/vpu_busy_counter.sv
// rtl/vpu_busy_counter.sv - 16-bit saturating busy-cycle counter
//
// Purpose: counts cycles while enabled, sticks at 16'hFFFF, and flags when
// the count has reached the terminal value TC_VAL.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr_i        force the count to zero (wins over en_i)
//   en_i         increment by one this cycle
//   cnt_inc_o    current count plus one, saturated (value after an enabled cycle)
//   tc_o         count has reached TC_VAL
module vpu_busy_counter #(
  parameter int TC_VAL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] cnt_inc_o,
  output logic        tc_o
);

  logic [15:0] cnt_q, cnt_d;

  assign cnt_inc_o = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign tc_o      = (cnt_q >= 16'(TC_VAL));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vpu_cmd_responder.sv
// rtl/vpu_cmd_responder.sv - VPU-side responder for the CPU/VPU command handshake
//
// Purpose: snapshots V0..V7 and RO on VPU_start, issues the command to the
// vector engine (valid/ready then done), and writes results back to the CPU
// with a one-cycle we_VPU strobe. Optional engine watchdog: VPU_TIMEOUT_EN.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   VPU_start, cpu_V, cpu_RO     command request and operands from the CPU
//   VPU_rdy                      idle or writing back
//   we_VPU, wb_V, wb_RO          write-back strobe and data to the CPU
//   eng_valid/ready, eng_cmd/opnd command issue to the engine
//   eng_done, eng_result, eng_ro engine completion and results
//   eng_abort                    watchdog abort pulse (0 without watchdog)
//   perf_cycles                  busy cycles of the last command, saturating
module vpu_cmd_responder
  import vpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int NUM_V       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    VPU_start,
  input  logic [NUM_V*DATA_W-1:0] cpu_V,
  input  logic [DATA_W-1:0]       cpu_RO,
  output logic                    VPU_rdy,
  output logic                    we_VPU,
  output logic [NUM_V*DATA_W-1:0] wb_V,
  output logic [DATA_W-1:0]       wb_RO,
  output logic                    eng_valid,
  input  logic                    eng_ready,
  output logic [DATA_W-1:0]       eng_cmd,
  output logic [NUM_V*DATA_W-1:0] eng_opnd,
  input  logic                    eng_done,
  input  logic [NUM_V*DATA_W-1:0] eng_result,
  input  logic [DATA_W-1:0]       eng_ro,
  output logic                    eng_abort,
  output logic [15:0]             perf_cycles
);

  localparam int VW = NUM_V * DATA_W;

  vpu_state_e        state_q, state_d;
  logic [VW-1:0]     opnd_q, opnd_d, wbv_q, wbv_d;
  logic [DATA_W-1:0] cmd_q, cmd_d, wbro_q, wbro_d;
  logic [15:0]       perf_q, perf_d;
  logic              abort_q, abort_d;
  logic              cnt_clr, cnt_en, tc, timeout;
  logic [15:0]       cnt_inc;

  vpu_busy_counter #(.TC_VAL(TIMEOUT_CYC)) u_busy (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .cnt_inc_o (cnt_inc),
    .tc_o      (tc)
  );

`ifdef VPU_TIMEOUT_EN
  assign timeout = tc;
`else
  logic tc_unused;
  assign tc_unused = tc;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    cmd_d   = cmd_q;
    wbv_d   = wbv_q;
    wbro_d  = wbro_q;
    perf_d  = perf_q;
    abort_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE, WB: begin
        // WB doubles as an accept slot so commands can run back-to-back.
        state_d = IDLE;
        if (VPU_start) begin
          opnd_d  = cpu_V;
          cmd_d   = cpu_RO;
          cnt_clr = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_en = 1'b1;
        if (eng_ready) begin
          state_d = WAIT;
          if (eng_done) begin
            wbv_d   = eng_result;
            wbro_d  = eng_ro;
            perf_d  = cnt_inc;
            state_d = WB;
          end
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        // A done arriving with the timeout still wins.
        if (eng_done) begin
          wbv_d   = eng_result;
          wbro_d  = eng_ro;
          perf_d  = cnt_inc;
          state_d = WB;
        end else if (timeout) begin
          wbv_d   = opnd_q;
          wbro_d  = DATA_W'(VPU_ERR_RO);
          perf_d  = cnt_inc;
          abort_d = 1'b1;
          state_d = WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      cmd_q   <= '0;
      wbv_q   <= '0;
      wbro_q  <= '0;
      perf_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      cmd_q   <= cmd_d;
      wbv_q   <= wbv_d;
      wbro_q  <= wbro_d;
      perf_q  <= perf_d;
      abort_q <= abort_d;
    end
  end

  assign VPU_rdy     = (state_q == IDLE) || (state_q == WB);
  assign we_VPU      = (state_q == WB);
  assign eng_valid   = (state_q == ISSUE);
  assign eng_cmd     = cmd_q;
  assign eng_opnd    = opnd_q;
  assign wb_V        = wbv_q;
  assign wb_RO       = wbro_q;
  assign perf_cycles = perf_q;
  assign eng_abort   = abort_q;

endmodule

// File: tb/tb_vpu_cmd_responder.sv
// tb/tb_vpu_cmd_responder.sv - self-checking bench for vpu_cmd_responder
module tb_vpu_cmd_responder;

  localparam int DATA_W = 16;
  localparam int NUM_V  = 8;
  localparam int VW     = DATA_W * NUM_V;

  logic              clk = 1'b0;
  logic              rst;
  logic              VPU_start;
  logic [VW-1:0]     cpu_V;
  logic [DATA_W-1:0] cpu_RO;
  logic              VPU_rdy, we_VPU, eng_valid, eng_ready, eng_done, eng_abort;
  logic [VW-1:0]     wb_V, eng_opnd, eng_result;
  logic [DATA_W-1:0] wb_RO, eng_cmd, eng_ro;
  logic [15:0]       perf_cycles;

  always #5 clk = ~clk;

  vpu_cmd_responder #(.DATA_W(DATA_W), .NUM_V(NUM_V), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .VPU_start   (VPU_start),
    .cpu_V       (cpu_V),
    .cpu_RO      (cpu_RO),
    .VPU_rdy     (VPU_rdy),
    .we_VPU      (we_VPU),
    .wb_V        (wb_V),
    .wb_RO       (wb_RO),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .eng_cmd     (eng_cmd),
    .eng_opnd    (eng_opnd),
    .eng_done    (eng_done),
    .eng_result  (eng_result),
    .eng_ro      (eng_ro),
    .eng_abort   (eng_abort),
    .perf_cycles (perf_cycles)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // V_i = RO argument + i + 1, so RO=16'h1000 gives V0..V7 = 1..8.
  function automatic logic [VW-1:0] opnd_of(input logic [15:0] cmd);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_V; i++) v[i*16 +: 16] = (cmd & 16'h0FFF) + 16'(i + 1);
    return v;
  endfunction

  // Engine result i = {ro[15:8], A0+i}; ro=16'h0042 gives A0..A7.
  function automatic logic [VW-1:0] res_of(input logic [15:0] ro);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_V; i++) v[i*16 +: 16] = {ro[15:8], 8'hA0 + 8'(i)};
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic dn,
                       input logic [15:0] cmd, input logic [15:0] ro);
    VPU_start  = st;
    eng_ready  = rd;
    eng_done   = dn;
    cpu_RO     = cmd;
    cpu_V      = opnd_of(cmd);
    eng_ro     = ro;
    eng_result = res_of(ro);
  endtask

  typedef struct packed {
    logic        start, ready, done;
    logic [15:0] cmd, ro;
    logic        e_rdy, e_we, e_valid;
    logic [15:0] e_cmd, e_ro, e_perf;
  } vec_t;

  vec_t vecs[20];

  int          t, s, a, dn, w;
  bit          active, seen, early_abort;
  logic [15:0] x_cmd, x_ro;
  logic [VW-1:0] x_v, x_res;

  initial begin
    // Columns: start ready done cmd ro | rdy we valid eng_cmd wb_RO perf
    vecs[0]  = '{1,0,0,16'h1000,16'h0000, 1,0,0,16'h0000,16'h0000,16'd0};
    vecs[1]  = '{0,1,0,16'h2222,16'h0000, 0,0,1,16'h1000,16'h0000,16'd0};
    vecs[2]  = '{0,0,0,16'h3333,16'h0000, 0,0,0,16'h1000,16'h0000,16'd0};
    vecs[3]  = '{0,0,0,16'h3333,16'h0000, 0,0,0,16'h1000,16'h0000,16'd0};
    vecs[4]  = '{0,0,1,16'h3333,16'h0042, 0,0,0,16'h1000,16'h0000,16'd0};
    vecs[5]  = '{0,0,0,16'h3333,16'h0099, 1,1,0,16'h1000,16'h0042,16'd4};
    vecs[6]  = '{1,0,0,16'h2005,16'h0000, 1,0,0,16'h1000,16'h0042,16'd4};
    vecs[7]  = '{0,0,0,16'h1111,16'h0000, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[8]  = '{0,0,0,16'h1111,16'h0000, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[9]  = '{0,0,1,16'h1111,16'hDEAD, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[10] = '{0,0,0,16'h1111,16'h0000, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[11] = '{0,0,0,16'h1111,16'h0000, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[12] = '{0,1,0,16'h7777,16'h0000, 0,0,1,16'h2005,16'h0042,16'd4};
    vecs[13] = '{1,0,0,16'h4444,16'h0000, 0,0,0,16'h2005,16'h0042,16'd4};
    vecs[14] = '{0,0,1,16'h4444,16'h0077, 0,0,0,16'h2005,16'h0042,16'd4};
    vecs[15] = '{1,0,0,16'h3ABC,16'h0000, 1,1,0,16'h2005,16'h0077,16'd8};
    vecs[16] = '{0,1,1,16'h5555,16'h0055, 0,0,1,16'h3ABC,16'h0077,16'd8};
    vecs[17] = '{0,0,0,16'h5555,16'h0000, 1,1,0,16'h3ABC,16'h0055,16'd1};
    vecs[18] = '{0,0,1,16'h5555,16'h0999, 1,0,0,16'h3ABC,16'h0055,16'd1};
    vecs[19] = '{0,0,0,16'h0000,16'h0000, 1,0,0,16'h3ABC,16'h0055,16'd1};

    rst = 1'b1;
    drive(0, 0, 0, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("rst_rdy",   VPU_rdy, 1);
    chk("rst_we",    we_VPU, 0);
    chk("rst_valid", eng_valid, 0);
    chk("rst_abort", eng_abort, 0);
    chk("rst_wbv",   wb_V, 0);
    chk("rst_wbro",  wb_RO, 0);
    chk("rst_cmd",   eng_cmd, 0);
    chk("rst_opnd",  eng_opnd, 0);
    chk("rst_perf",  perf_cycles, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("v%0d_rdy", i),   VPU_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_we", i),    we_VPU, vecs[i].e_we);
      chk($sformatf("v%0d_valid", i), eng_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_cmd", i),   eng_cmd, vecs[i].e_cmd);
      if (vecs[i].e_cmd != 16'h0000) chk($sformatf("v%0d_opnd", i), eng_opnd, opnd_of(vecs[i].e_cmd));
      chk($sformatf("v%0d_wbro", i),  wb_RO, vecs[i].e_ro);
      chk($sformatf("v%0d_perf", i),  perf_cycles, vecs[i].e_perf);
      chk($sformatf("v%0d_abort", i), eng_abort, 0);
      if (vecs[i].e_we) chk($sformatf("v%0d_wbv", i), wb_V, res_of(vecs[i].e_ro));
      drive(vecs[i].start, vecs[i].ready, vecs[i].done, vecs[i].cmd, vecs[i].ro);
      tick();
    end

    // Randomized traffic; each command is scheduled up front: accept cycle a,
    // done cycle dn, write-back at dn+1, busy cycles = dn - s.
    active = 0;
    t = 0;
    while ((t < 400 || active) && t < 600) begin
      if (active) begin
        chk("rnd_rdy",   VPU_rdy, (t == w));
        chk("rnd_we",    we_VPU, (t == w));
        chk("rnd_valid", eng_valid, (t <= a));
        if (t <= a) begin
          chk("rnd_cmd",  eng_cmd, x_cmd);
          chk("rnd_opnd", eng_opnd, x_v);
        end
        if (t == w) begin
          chk("rnd_wbro", wb_RO, x_ro);
          chk("rnd_wbv",  wb_V, x_res);
          chk("rnd_perf", perf_cycles, 16'(dn - s));
          active = 0;
        end
      end else begin
        chk("rnd_idle_rdy",   VPU_rdy, 1);
        chk("rnd_idle_we",    we_VPU, 0);
        chk("rnd_idle_valid", eng_valid, 0);
      end
      chk("rnd_abort", eng_abort, 0);

      VPU_start  = 1'b0;
      eng_ready  = 1'($urandom);
      eng_done   = 1'($urandom);
      cpu_RO     = 16'($urandom);
      cpu_V      = rand_vec();
      eng_ro     = 16'($urandom);
      eng_result = rand_vec();
      if (!active && t < 400 && $urandom_range(0, 1) == 1) begin
        VPU_start = 1'b1;
        s      = t;
        a      = s + 1 + int'($urandom_range(0, 3));
        dn     = a + int'($urandom_range(0, 4));
        w      = dn + 1;
        x_cmd  = cpu_RO;
        x_v    = cpu_V;
        active = 1;
      end else if (active && $urandom_range(0, 3) == 0) begin
        VPU_start = 1'b1;
      end
      if (active) begin
        if (t == s) eng_done = 1'b0;
        else if (t < a) eng_ready = 1'b0;
        else if (t == a) eng_ready = 1'b1;
        if (t >= a && t < dn) eng_done = 1'b0;
        if (t == dn) begin
          eng_done = 1'b1;
          x_ro     = eng_ro;
          x_res    = eng_result;
        end
      end
      tick();
      t++;
    end

    // Reset while waiting on the engine: command is abandoned silently.
    drive(1, 0, 0, 16'h1ABC, 16'h0000);
    tick();
    drive(0, 1, 0, 16'h0000, 16'h0000);
    tick();
    drive(0, 0, 0, 16'h0000, 16'h0000);
    tick();
    chk("mid_in_wait", VPU_rdy, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy",   VPU_rdy, 1);
    chk("mid_rst_we",    we_VPU, 0);
    chk("mid_rst_abort", eng_abort, 0);
    chk("mid_rst_valid", eng_valid, 0);
    chk("mid_rst_perf",  perf_cycles, 0);
    chk("mid_rst_cmd",   eng_cmd, 0);
    rst = 1'b0;
    drive(0, 1, 1, 16'h0000, 16'h0033);
    tick();
    chk("post_rst_we1", we_VPU, 0);
    chk("post_rst_rdy", VPU_rdy, 1);
    drive(0, 0, 0, 16'h0000, 16'h0000);
    tick();
    chk("post_rst_we2", we_VPU, 0);
    chk("post_rst_wbro", wb_RO, 0);

`ifdef VPU_TIMEOUT_EN
    drive(1, 0, 0, 16'h0123, 16'h0000);
    tick();
    drive(0, 1, 0, 16'h0000, 16'h0000);
    tick();
    drive(0, 0, 0, 16'h0000, 16'h0000);
    seen = 0;
    early_abort = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (we_VPU) seen = 1;
      else if (eng_abort) early_abort = 1;
    end
    chk("to_we_seen",     seen, 1);
    chk("to_early_abort", early_abort, 0);
    chk("to_abort",       eng_abort, 1);
    chk("to_wbro",        wb_RO, 16'hFFFF);
    chk("to_wbv_echo",    wb_V, opnd_of(16'h0123));
    tick();
    chk("to_abort_clr",   eng_abort, 0);
    chk("to_we_clr",      we_VPU, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_responder.md
# vpu_cmd_responder

VPU-side responder for the CPU↔VPU command handshake. It accepts `VPU_start` from the CPU decode/execute stage and snapshots the V0–V7 operands and the RO command word. It then issues the command to the vector engine over a valid/ready + done handshake and returns results to the CPU register file with a one-cycle `we_VPU` write-back pulse, holding `VPU_rdy` low while busy. It sits between the CPU pipeline and the VPU datapath, inside the VPU top.

## Interface
Parameters:
- DATA_W, 16, width of each V register and RO
- NUM_V, 8, number of vector operand registers
- TIMEOUT_CYC, 1024, engine watchdog limit in cycles (used only with the watchdog compiled in)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- VPU_start  in  1  command request from the CPU; sampled only while `VPU_rdy`=1
- cpu_V  in  NUM_V*DATA_W  operands {V7..V0} from the CPU register file
- cpu_RO  in  DATA_W  command word; [15:12] is the engine op, [11:0] is the argument
- VPU_rdy  out  1  1 = idle or writing back, can accept a command
- we_VPU  out  1  one-cycle write-back strobe to the CPU register file
- wb_V  out  NUM_V*DATA_W  write-back values {V7..V0}, valid while `we_VPU`=1
- wb_RO  out  DATA_W  return object, valid while `we_VPU`=1
- eng_valid  out  1  command valid to the engine
- eng_ready  in  1  engine accepts the command
- eng_cmd  out  DATA_W  latched `cpu_RO`
- eng_opnd  out  NUM_V*DATA_W  latched `cpu_V`
- eng_done  in  1  engine completion pulse
- eng_result  in  NUM_V*DATA_W  engine V results, valid with `eng_done`
- eng_ro  in  DATA_W  engine return object, valid with `eng_done`
- eng_abort  out  1  one-cycle abort pulse to the engine (watchdog builds only; tied 0 otherwise)
- perf_cycles  out  16  busy cycles of the last command, saturating

## Operation
States:
- **IDLE**
  - `VPU_rdy`=1.
  - If `VPU_start`=1: latch `cpu_V`/`cpu_RO`, clear the busy counter, go to ISSUE.
- **ISSUE**
  - `eng_valid`=1; `eng_cmd`/`eng_opnd` are held stable.
  - If `eng_ready`=1 and `eng_done`=1 in the same cycle: capture results, go to WB.
  - If `eng_ready`=1 only: go to WAIT.
  - `eng_valid` never drops before `eng_ready`.
- **WAIT**
  - `eng_valid`=0.
  - On `eng_done`=1: capture `eng_result`/`eng_ro` into `wb_V`/`wb_RO`, go to WB.
  - `eng_done` is ignored in IDLE, and in ISSUE unless accompanied by `eng_ready`.
- **WB**
  - `we_VPU`=1 and `VPU_rdy`=1 for exactly one cycle; `perf_cycles` is updated.
  - If `VPU_start`=1 in WB: latch the new command and go straight to ISSUE (back-to-back).
  - Otherwise go to IDLE.

Rules:
- `VPU_start` while `VPU_rdy`=0 is ignored; it is never queued.
- Busy counter: increments every cycle in ISSUE/WAIT, saturates at 16'hFFFF, is copied to `perf_cycles` on WB entry.
- `wb_V`/`wb_RO` hold their last values outside WB.

## Timing
- Reset values:
  - State is IDLE.
  - `VPU_rdy`=1.
  - `we_VPU`, `eng_valid`, `eng_abort` = 0.
  - `wb_V`, `wb_RO`, `eng_cmd`, `eng_opnd`, `perf_cycles` = 0.
- Reset mid-operation: abandon the command with no write-back and no `eng_abort`. The engine is reset by the same `rst`.
- Latency with `eng_ready`=1 at ISSUE and `eng_done` D cycles after acceptance:
  - `VPU_start` at cycle 0 → `eng_valid` at cycle 1 → `we_VPU` at cycle 2+D.
  - Same-cycle done (D=0) → `we_VPU` at cycle 2.
- `VPU_rdy` falls the cycle after `VPU_start` is accepted and rises in the WB cycle.
- All outputs are registered except none; no combinational input→output paths.

## Configuration
- `VPU_TIMEOUT_EN` defined: the watchdog is compiled in.
  - In WAIT, if the busy counter reaches TIMEOUT_CYC without `eng_done`, pulse `eng_abort` for one cycle and go to WB.
  - Write-back then uses `wb_V` = latched operands (echo) and `wb_RO` = 16'hFFFF (error code).
  - `eng_done` arriving in the same cycle as the timeout wins (normal write-back).
- `VPU_TIMEOUT_EN` undefined: no watchdog; WAIT waits indefinitely; `eng_abort` is constant 0.

## Structure
- Shared package `vpu_pkg`:
  - state enum {IDLE, ISSUE, WAIT, WB}
  - `VPU_ERR_RO` = 16'hFFFF
  - op-field slice constants for RO[15:12]
- One sub-module: `vpu_busy_counter`, a 16-bit saturating counter with clear, enable and a terminal-compare output (`tc` for TIMEOUT_CYC).

## Test plan
- Reset, then `VPU_start` with V0..V7=1..8, RO=16'h1000; `eng_ready`=1; `eng_done` 3 cycles later with results 16'hA0..A7, ro=16'h0042 → `we_VPU` at cycle 5, `wb_V`=A0..A7, `wb_RO`=16'h0042, `perf_cycles`=4.
- Hold `eng_ready`=0 for 5 cycles → `eng_valid` stays 1 and `eng_cmd`/`eng_opnd` stay stable throughout; write-back only after done.
- `VPU_start` pulsed during WAIT → ignored; exactly one `we_VPU`; second command accepted only when re-asserted in WB → ISSUE the next cycle.
- `eng_ready` and `eng_done` in the same ISSUE cycle → `we_VPU` on the following cycle, `VPU_rdy`=1 that cycle.
- `VPU_TIMEOUT_EN`, TIMEOUT_CYC=8, no `eng_done` → `eng_abort` pulse, `wb_RO`=16'hFFFF, `wb_V`=operands echoed.
- `rst` asserted in WAIT → next cycle IDLE, `VPU_rdy`=1, no `we_VPU`, `eng_abort`=0.
